// File: rtl/silver_arbiter.sv
// silver_arbiter: registered 2x2 steering stage of the MinBD permutation network.
// Resolves port contention by golden/silver/ordinary class with a round-robin tie-break.
module silver_arbiter #(
  parameter int MY_X         = 0,
  parameter int MY_Y         = 0,
  parameter int STAGE        = 0,
  parameter int CLEAR_SILVER = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] in0_flit,
  input  logic        in0_valid,
  input  logic [10:0] in1_flit,
  input  logic        in1_valid,
  output logic [10:0] out0_flit,
  output logic        out0_valid,
  output logic [10:0] out1_flit,
  output logic        out1_valid,
  output logic [15:0] deflect_cnt
);

  localparam logic [2:0] MX = 3'(MY_X);
  localparam logic [2:0] MY = 3'(MY_Y);

  // 1 means the flit's productive port is output 1
  function automatic logic port_of(input logic [10:0] f);
    logic [2:0] dx;
    logic [2:0] dy;
    dx = f[5:3];
    dy = f[2:0];
    if (STAGE == 0)
      port_of = (dx == MX);
    else if (dx != MX)
      port_of = !(dx > MX);
    else
      port_of = !(dy > MY);
  endfunction

  function automatic logic [1:0] cls_of(input logic [10:0] f);
    cls_of = f[10] ? 2'd2 : (f[9] ? 2'd1 : 2'd0);
  endfunction

  function automatic logic [10:0] scrub(input logic [10:0] f);
    scrub = (CLEAR_SILVER != 0) ? {f[10], 1'b0, f[8:0]} : f;
  endfunction

  logic        rr_ptr;
  logic        p0;
  logic        p1;
  logic [1:0]  c0;
  logic [1:0]  c1;
  logic        conflict;
  logic        tie;
  logic        win1;
  logic [10:0] wf;
  logic [10:0] lf;
  logic [10:0] nf0;
  logic [10:0] nf1;
  logic        nv0;
  logic        nv1;

  assign p0 = port_of(in0_flit);
  assign p1 = port_of(in1_flit);
  assign c0 = cls_of(in0_flit);
  assign c1 = cls_of(in1_flit);

  always_comb begin
    nf0      = '0;
    nf1      = '0;
    nv0      = 1'b0;
    nv1      = 1'b0;
    conflict = 1'b0;
    tie      = 1'b0;
    win1     = 1'b0;
    wf       = '0;
    lf       = '0;
    unique case (1'b1)
      in0_valid && in1_valid && (p0 == p1): begin
        conflict = 1'b1;
        tie      = (c0 == c1);
        win1     = tie ? rr_ptr : (c1 > c0);
        wf       = win1 ? in1_flit : in0_flit;
        lf       = win1 ? in0_flit : in1_flit;
        nv0      = 1'b1;
        nv1      = 1'b1;
        // winner on the shared productive port, loser deflected
        if (p0) begin
          nf1 = wf;
          nf0 = lf;
        end else begin
          nf0 = wf;
          nf1 = lf;
        end
      end
      in0_valid && in1_valid && (p0 != p1): begin
        nv0 = 1'b1;
        nv1 = 1'b1;
        nf0 = p0 ? in1_flit : in0_flit;
        nf1 = p0 ? in0_flit : in1_flit;
      end
      in0_valid && !in1_valid: begin
        if (p0) begin
          nv1 = 1'b1;
          nf1 = in0_flit;
        end else begin
          nv0 = 1'b1;
          nf0 = in0_flit;
        end
      end
      !in0_valid && in1_valid: begin
        if (p1) begin
          nv1 = 1'b1;
          nf1 = in1_flit;
        end else begin
          nv0 = 1'b1;
          nf0 = in1_flit;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_flit   <= '0;
      out0_valid  <= 1'b0;
      out1_flit   <= '0;
      out1_valid  <= 1'b0;
      rr_ptr      <= 1'b0;
      deflect_cnt <= '0;
    end else begin
      out0_flit  <= scrub(nf0);
      out0_valid <= nv0;
      out1_flit  <= scrub(nf1);
      out1_valid <= nv1;
      rr_ptr     <= rr_ptr ^ tie;
      if (conflict && (deflect_cnt != 16'hFFFF))
        deflect_cnt <= deflect_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_silver_arbiter.sv
// tb_silver_arbiter: scoreboard bench for two silver_arbiter configurations
// (first stage, and last stage with silver clearing) sharing one input stream.
module tb_silver_arbiter;

  typedef struct packed {
    logic [10:0] o0;
    logic        v0;
    logic [10:0] o1;
    logic        v1;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [10:0] in0_flit;
  logic        in0_valid;
  logic [10:0] in1_flit;
  logic        in1_valid;

  logic [10:0] a_o0, a_o1, b_o0, b_o1;
  logic        a_v0, a_v1, b_v0, b_v1;
  logic [15:0] a_cnt, b_cnt;

  int n_chk;
  int n_pass;

  exp_t q0[$];
  exp_t q1[$];
  bit   rr_m[2];
  int   cnt_m[2];

  silver_arbiter #(.MY_X(2), .MY_Y(2), .STAGE(0), .CLEAR_SILVER(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .in0_flit(in0_flit), .in0_valid(in0_valid),
    .in1_flit(in1_flit), .in1_valid(in1_valid),
    .out0_flit(a_o0), .out0_valid(a_v0),
    .out1_flit(a_o1), .out1_valid(a_v1),
    .deflect_cnt(a_cnt)
  );

  silver_arbiter #(.MY_X(2), .MY_Y(2), .STAGE(1), .CLEAR_SILVER(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .in0_flit(in0_flit), .in0_valid(in0_valid),
    .in1_flit(in1_flit), .in1_valid(in1_valid),
    .out0_flit(b_o0), .out0_valid(b_v0),
    .out1_flit(b_o1), .out1_valid(b_v1),
    .deflect_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // wants output 1?
  function automatic bit hi_port(input int i, input logic [10:0] f);
    int dx, dy;
    dx = int'(f[5:3]);
    dy = int'(f[2:0]);
    if (i == 0) return dx == 2;
    if (dx != 2) return dx < 2;
    return dy <= 2;
  endfunction

  function automatic int klass(input logic [10:0] f);
    if (f[10]) return 2;
    if (f[9]) return 1;
    return 0;
  endfunction

  task automatic model(input int i, input logic va, input logic [10:0] fa,
                       input logic vb, input logic [10:0] fb,
                       output exp_t e);
    logic [10:0] o[2];
    logic        v[2];
    bit pa, pb, bwins;
    o[0] = '0; o[1] = '0; v[0] = 0; v[1] = 0;
    pa = hi_port(i, fa);
    pb = hi_port(i, fb);
    if (va && vb && pa == pb) begin
      if (klass(fa) != klass(fb)) bwins = klass(fb) > klass(fa);
      else begin
        bwins = rr_m[i];
        rr_m[i] = !rr_m[i];
      end
      o[pa]  = bwins ? fb : fa;
      o[!pa] = bwins ? fa : fb;
      v[0] = 1; v[1] = 1;
      if (cnt_m[i] < 65535) cnt_m[i]++;
    end else begin
      if (va) begin o[pa] = fa; v[pa] = 1; end
      if (vb) begin o[pb] = fb; v[pb] = 1; end
    end
    if (i == 1) begin
      o[0][9] = 1'b0;
      o[1][9] = 1'b0;
    end
    e.o0 = o[0]; e.v0 = v[0]; e.o1 = o[1]; e.v1 = v[1];
    e.cnt = 16'(cnt_m[i]);
  endtask

  task automatic drive(input logic va, input logic [10:0] fa,
                       input logic vb, input logic [10:0] fb);
    exp_t e;
    @(negedge clk);
    in0_valid = va; in0_flit = fa;
    in1_valid = vb; in1_flit = fb;
    model(0, va, fa, vb, fb, e); q0.push_back(e);
    model(1, va, fa, vb, fb, e); q1.push_back(e);
    @(posedge clk);
    #1;
    e = q0.pop_front();
    check("u0_route", {8'h0, a_o0, a_v0, a_o1, a_v1}, {8'h0, e.o0, e.v0, e.o1, e.v1});
    check("u0_cnt", {16'h0, a_cnt}, {16'h0, e.cnt});
    e = q1.pop_front();
    check("u1_route", {8'h0, b_o0, b_v0, b_o1, b_v1}, {8'h0, e.o0, e.v0, e.o1, e.v1});
    check("u1_cnt", {16'h0, b_cnt}, {16'h0, e.cnt});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_u0"}, {a_o0, a_v0, a_o1, a_v1, a_cnt}, 40'h0);
    check({tag, "_u1"}, {b_o0, b_v0, b_o1, b_v1, b_cnt}, 40'h0);
  endtask

  task automatic model_reset();
    rr_m[0] = 0; rr_m[1] = 0;
    cnt_m[0] = 0; cnt_m[1] = 0;
    q0.delete(); q1.delete();
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    model_reset();
    rst_n = 1'b0;
    in0_flit = '0; in0_valid = 0;
    in1_flit = '0; in1_valid = 0;
    #12;
    check_zero("reset");
    #1 rst_n = 1'b1;

    // traffic then a mid-stream reset
    drive(1, 11'h018, 1, 11'h028);
    drive(1, 11'h218, 1, 11'h428);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    model_reset();
    drive(0, '0, 0, '0);
    #1 rst_n = 1'b1;
    drive(0, '0, 0, '0);
    drive(0, '0, 0, '0);
    check_zero("idle");

    drive(1, 11'h018, 1, 11'h012);
    check("pass_o0", {21'h0, a_o0}, 32'h018);
    check("pass_o1", {21'h0, a_o1}, 32'h012);
    check("pass_cnt", {16'h0, a_cnt}, 32'h0);

    drive(1, 11'h218, 1, 11'h428);
    check("gold_o0", {21'h0, a_o0}, 32'h428);
    check("gold_o1", {21'h0, a_o1}, 32'h218);
    check("gold_cnt", {16'h0, a_cnt}, 32'h1);

    drive(1, 11'h018, 1, 11'h028);
    check("rr1", {21'h0, a_o0}, 32'h018);
    drive(1, 11'h018, 1, 11'h028);
    check("rr2", {21'h0, a_o0}, 32'h028);
    drive(1, 11'h018, 1, 11'h028);
    check("rr3", {21'h0, a_o0}, 32'h018);
    check("rr_cnt", {16'h0, a_cnt}, 32'h4);

    drive(0, '0, 1, 11'h213);
    check("clr_o0", {20'h0, b_v0, b_o0}, {20'h0, 1'b1, 11'h013});
    check("clr_v1", {31'h0, b_v1}, 32'h0);

    for (int k = 0; k < 400; k++)
      drive(1'($urandom), 11'($urandom), 1'($urandom), 11'($urandom));

    for (int k = 0; k < 65540; k++)
      drive(1, 11'h018, 1, 11'h028);
    check("sat_u0", {16'h0, a_cnt}, 32'hFFFF);
    check("sat_u1", {16'h0, b_cnt}, 32'hFFFF);
    drive(1, 11'h218, 1, 11'h428);
    check("sat_gold", {21'h0, a_o0}, 32'h428);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
